// File: rtl/pix_frame_reader.sv
// Raster-scan readback of pixel memory: reads every pixel in row-major order and
// streams it out tagged with (x, y), yielding to pipeline pixel writes.
module pix_frame_reader #(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CRD_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pipe_pix_write,
    output logic              pix_rd_en,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [PIX_W-1:0]  pix_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_data,
    output logic [CRD_W-1:0]  out_x,
    output logic [CRD_W-1:0]  out_y,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int unsigned ENT_W = PIX_W + 2 * CRD_W + 1;
    localparam logic [CRD_W-1:0] X_MAX = CRD_W'(IMG_W - 1);
    localparam logic [CRD_W-1:0] Y_MAX = CRD_W'(IMG_H - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CRD_W-1:0]  rx;
    logic [CRD_W-1:0]  ry;
    logic [ADDR_W-1:0] addr;
    logic [CRD_W-1:0]  tag_x;
    logic [CRD_W-1:0]  tag_y;
    logic              tag_last;
    logic              inflight;
    logic [1:0]        count;
    logic [ENT_W-1:0]  head;
    logic [ENT_W-1:0]  tail;
    logic [ENT_W-1:0]  incoming;
    logic [2:0]        credit_use;
    logic              issue;
    logic              pop;
    logic              push;
    logic              at_last;

    // Credits: a read is only issued if its return is guaranteed a FIFO slot.
    assign pop        = out_valid & out_ready;
    assign push       = inflight;
    assign at_last    = (rx == X_MAX) && (ry == Y_MAX);
    assign credit_use = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue      = (state == SCAN) && !pipe_pix_write && (credit_use < 3'd2);

    assign pix_rd_en = issue;
    assign pix_addr  = addr;
    assign busy      = (state != IDLE);
    assign done      = (state == DRAIN) && pop && out_last;
    assign out_valid = (count != 2'd0);
    assign incoming  = {pix_rdata, tag_x, tag_y, tag_last};
    assign {out_data, out_x, out_y, out_last} = head;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (issue && at_last) state_nxt = DRAIN;
            DRAIN:   if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Scan position; addr tracks ry*IMG_W+rx incrementally.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            rx   <= '0;
            ry   <= '0;
            addr <= '0;
        end else if (issue) begin
            addr <= addr + ADDR_W'(1);
            if (rx == X_MAX) begin
                rx <= '0;
                ry <= ry + CRD_W'(1);
            end else begin
                rx <= rx + CRD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            tag_x    <= '0;
            tag_y    <= '0;
            tag_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_x    <= rx;
                tag_y    <= ry;
                tag_last <= at_last;
            end
        end
    end

    // Two-entry FIFO; head register drives the stream outputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push && pop) begin
                if (count == 2'd2) begin
                    head <= tail;
                    tail <= incoming;
                end else begin
                    head <= incoming;
                end
            end else if (pop) begin
                head <= tail;
            end else if (push) begin
                if (count == 2'd0) head <= incoming;
                else               tail <= incoming;
            end
        end
    end

endmodule

// File: tb/tb_pix_frame_reader.sv
// Scoreboard bench for pix_frame_reader: a 4x2 instance under directed and random
// flow control, and a 3x3 instance for non-power-of-two wrap.
module tb_pix_frame_reader;

    localparam int unsigned AW = 16;
    localparam int unsigned CW = 16;

    typedef struct {
        int d;
        int x;
        int y;
        int last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pipe = 1'b0;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [7:0]    rdata = 8'd0;
    logic          ov;
    logic          ordy = 1'b1;
    logic [7:0]    odata;
    logic [CW-1:0] ox;
    logic [CW-1:0] oy;
    logic          olast;
    logic          busy;
    logic          done;

    logic          start_b = 1'b0;
    logic          pipe_b = 1'b0;
    logic          rd_en_b;
    logic [AW-1:0] addr_b;
    logic [7:0]    rdata_b = 8'd0;
    logic          ov_b;
    logic          ordy_b = 1'b1;
    logic [7:0]    odata_b;
    logic [CW-1:0] ox_b;
    logic [CW-1:0] oy_b;
    logic          olast_b;
    logic          busy_b;
    logic          done_b;

    pix_frame_reader #(.IMG_W(4), .IMG_H(2), .PIX_W(8), .ADDR_W(AW), .CRD_W(CW)) dut_a (
        .clk(clk), .rst(rst), .start(start), .pipe_pix_write(pipe),
        .pix_rd_en(rd_en), .pix_addr(addr), .pix_rdata(rdata),
        .out_valid(ov), .out_ready(ordy), .out_data(odata), .out_x(ox), .out_y(oy),
        .out_last(olast), .busy(busy), .done(done)
    );

    pix_frame_reader #(.IMG_W(3), .IMG_H(3), .PIX_W(8), .ADDR_W(AW), .CRD_W(CW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pipe_pix_write(pipe_b),
        .pix_rd_en(rd_en_b), .pix_addr(addr_b), .pix_rdata(rdata_b),
        .out_valid(ov_b), .out_ready(ordy_b), .out_data(odata_b), .out_x(ox_b), .out_y(oy_b),
        .out_last(olast_b), .busy(busy_b), .done(done_b)
    );

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    beat_t exp_qb[$];
    int    mode = 0;
    int    phase = 0;
    logic  pipe_dir = 1'b0;
    int    done_cnt = 0;
    int    done_cnt_b = 0;
    int    idx_a = 0;
    int    idx_b = 0;

    function automatic int mem_a(input int a);
        return (a + 16) % 256;
    endfunction

    function automatic int mem_b(input int a);
        return (a * 5 + 1) % 256;
    endfunction

    // Pixel memories: one-cycle registered read.
    always @(posedge clk) begin
        if (rd_en)   rdata   <= 8'(mem_a(int'(addr)));
        if (rd_en_b) rdata_b <= 8'(mem_b(int'(addr_b)));
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: full frame in raster order.
    task automatic push_frame(input int w, input int h, input bit is_b);
        beat_t e;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                e.x    = x;
                e.y    = y;
                e.d    = is_b ? mem_b(y * w + x) : mem_a(y * w + x);
                e.last = (x == w - 1 && y == h - 1) ? 1 : 0;
                if (is_b) exp_qb.push_back(e);
                else      exp_q.push_back(e);
            end
        end
    endtask

    // Flow-control driver.
    always @(posedge clk) begin
        #1;
        case (mode)
            0: begin
                ordy = 1'b1;
                pipe = pipe_dir;
            end
            1: begin
                ordy  = (phase == 0 || phase == 3);
                phase = (phase + 1) % 4;
                pipe  = ($urandom % 4 == 0);
            end
            default: begin
                ordy = 1'($urandom % 2);
                pipe = ($urandom % 3 == 0);
            end
        endcase
        pipe_b = ($urandom % 3 == 0);
    end

    // Monitor A.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            idx_a = 0;
        end else begin
            if (pipe) chk("no_read_during_write", int'(rd_en), 0);
            if (rd_en) begin
                chk("rd_addr", int'(addr), idx_a);
                idx_a++;
            end
            chk("fifo_occupancy_le2", int'(dut_a.count <= 2'd2), 1);
            if (ov) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("out_data", int'(odata), e.d);
                    chk("out_x", int'(ox), e.x);
                    chk("out_y", int'(oy), e.y);
                    chk("out_last", int'(olast), e.last);
                    if (ordy) void'(exp_q.pop_front());
                end
            end
            if (done || (ov && ordy && olast)) chk("done_with_last", int'(done), int'(ov && ordy && olast));
            if (done) begin
                done_cnt++;
                idx_a = 0;
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            idx_b = 0;
        end else begin
            if (pipe_b) chk("b_no_read_during_write", int'(rd_en_b), 0);
            if (rd_en_b) begin
                chk("b_rd_addr", int'(addr_b), idx_b);
                idx_b++;
            end
            if (ov_b) begin
                if (exp_qb.size() == 0) begin
                    chk("b_unexpected_beat", 1, 0);
                end else begin
                    e = exp_qb[0];
                    chk("b_out_data", int'(odata_b), e.d);
                    chk("b_out_x", int'(ox_b), e.x);
                    chk("b_out_y", int'(oy_b), e.y);
                    chk("b_out_last", int'(olast_b), e.last);
                    if (ordy_b) void'(exp_qb.pop_front());
                end
            end
            if (done_b) done_cnt_b++;
        end
    end

    task automatic check_reset();
        chk("rst_pix_rd_en", int'(rd_en), 0);
        chk("rst_pix_addr", int'(addr), 0);
        chk("rst_out_valid", int'(ov), 0);
        chk("rst_out_data", int'(odata), 0);
        chk("rst_out_x", int'(ox), 0);
        chk("rst_out_y", int'(oy), 0);
        chk("rst_out_last", int'(olast), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
    endtask

    // exp_n: cycle of done after the start edge (0 = unchecked); pw_lo..pw_hi: write stall cycles.
    task automatic run_frame(input int exp_n, input int pw_lo, input int pw_hi, input int restart_at);
        int n;
        int d0;
        bit got;
        @(posedge clk);
        #2;
        start = 1'b1;
        push_frame(4, 2, 1'b0);
        d0 = done_cnt;
        @(posedge clk);
        #2;
        start = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_after_start", int'(busy), 1);
            if (exp_n > 0 && n == 1) chk("first_rd_en", int'(rd_en), 1);
            if (exp_n > 0 && n == 2) chk("valid_not_early", int'(ov), 0);
            if (exp_n > 0 && n == 3) chk("first_valid", int'(ov), 1);
            if (done) got = 1'b1;
            pipe_dir = (n + 1 >= pw_lo && n + 1 <= pw_hi);
            start    = (n == restart_at);
        end
        pipe_dir = 1'b0;
        start    = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
        else if (exp_n > 0) chk("done_cycle", n, exp_n);
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        chk("one_done_per_frame", done_cnt - d0, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset();

        mode = 0;
        run_frame(10, 0, -1, 0);
        run_frame(13, 2, 4, 0);

        mode = 1;
        run_frame(0, 0, -1, 0);
        mode = 0;
        repeat (2) @(posedge clk);

        run_frame(10, 0, -1, 3);

        // Reset mid-scan, sampled at edge T0+4.
        @(posedge clk);
        #2;
        start = 1'b1;
        push_frame(4, 2, 1'b0);
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset();
        @(negedge clk);
        chk("late_return_discarded", int'(ov), 0);
        run_frame(10, 0, -1, 0);

        mode = 2;
        for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_frame(0, 0, -1, 0);
        end
        mode = 0;

        @(posedge clk);
        #2;
        start_b = 1'b1;
        push_frame(3, 3, 1'b1);
        @(posedge clk);
        #2;
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done_b) chk("b_done_timeout", 0, 1);
        @(negedge clk);
        chk("b_one_done", done_cnt_b, 1);
        chk("b_queue_drained", exp_qb.size(), 0);
        chk("b_busy_after_done", int'(busy_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pix_frame_reader.md
# pix_frame_reader

Raster-scan readback engine for the pixel memory. The execute/memory stages write pixels into pixel memory; this block is the read side of that path. On `start` it reads every pixel in row-major order and streams each one out on a valid/ready interface, tagged with its (x, y) coordinates, for display or host dump. Pipeline pixel writes always have priority: the reader never issues a read in a cycle where the pipeline writes pixel memory.

## Interface
Parameters:
- `IMG_W`, 256: image width in pixels (≥2)
- `IMG_H`, 256: image height in pixels (≥1)
- `PIX_W`, 8: pixel data width
- `ADDR_W`, 16: pixel memory address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H
- `CRD_W`, 16: width of the x/y coordinate outputs

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a frame scan; sampled only in IDLE
- `pipe_pix_write` in 1: pipeline is writing pixel memory this cycle (memPixWrite from the EXE/MEM stage)
- `pix_rd_en` out 1: pixel memory read strobe
- `pix_addr` out ADDR_W: read address, equal to y·IMG_W + x
- `pix_rdata` in PIX_W: read data, valid exactly 1 cycle after `pix_rd_en`
- `out_valid` out 1: stream data valid
- `out_ready` in 1: downstream accepts data
- `out_data` out PIX_W: pixel value
- `out_x` out CRD_W, `out_y` out CRD_W: coordinates of the pixel on `out_data`
- `out_last` out 1: the current beat is pixel (IMG_W−1, IMG_H−1)
- `busy` out 1: a scan is in progress
- `done` out 1: one-cycle pulse when the last beat is accepted

## Operation
- FSM states:
  - IDLE: `busy`=0.
    - `start`=1 → SCAN. Scan counters rx=0, ry=0.
  - SCAN: issues reads.
    - When the read of (IMG_W−1, IMG_H−1) is issued → DRAIN.
  - DRAIN: no further reads.
    - When the last beat handshakes (`out_valid`&`out_ready`&`out_last`) → IDLE, with `done`=1 that cycle.
- Read issue in SCAN, with issue = !`pipe_pix_write` && (count + inflight − pop) < 2:
  - count = output FIFO occupancy (0..2).
  - inflight = 1 if a read was issued last cycle.
  - pop = `out_valid`&`out_ready` this cycle.
- On issue:
  - `pix_rd_en`=1 and `pix_addr`={ry·IMG_W+rx} truncated to ADDR_W.
  - rx increments. When rx=IMG_W−1 it wraps to 0 and ry increments.
  - The coordinate pair enters a 1-deep in-flight tag register.
- Output path:
  - The cycle after an issue, {`pix_rdata`, tag x, tag y, last flag} is pushed into a 2-entry FIFO.
  - The FIFO head drives the out_* signals. `out_valid` = (count ≠ 0).
  - Push and pop may occur in the same cycle. Occupancy is then unchanged and order is preserved.
  - The credit rule guarantees the FIFO never overflows. Overflow is a design error; the bench asserts against it.
- Stream rule: once `out_valid`=1, `out_data`, `out_x`, `out_y` and `out_last` stay stable until accepted.
- `start` while `busy`=1 is ignored.
- `pipe_pix_write` held high stalls issue indefinitely; no reads are lost or duplicated.
- `rst` mid-scan: at the next edge the FSM goes to IDLE and the counters, FIFO and in-flight tag clear. Any read return arriving the following cycle is discarded.
- `out_x`, `out_y` are zero-extended to CRD_W.

## Timing
- Reset values: `pix_rd_en`=0, `pix_addr`=0, `out_valid`=0, `out_data`=0, `out_x`=0, `out_y`=0, `out_last`=0, `busy`=0, `done`=0.
- `start` sampled at edge T0 → `busy`=1 and first `pix_rd_en` during cycle T0+1, assuming no write conflict.
- First `out_valid` in cycle T0+3: read issued in T0+1, data returned in T0+2, registered into FIFO, visible in T0+3.
- Throughput: 1 pixel/cycle with `out_ready`=1 and `pipe_pix_write`=0.
- Total frame: IMG_W·IMG_H + 2 cycles from first read to `done` when unstalled.
- `done` is asserted in the same cycle as the last handshake. `busy` drops in the following cycle.
- `start` is accepted again in the cycle after `done`.
- `out_ready` low: at most 2 buffered beats plus 0 in flight. Issue resumes the cycle a pop frees a credit.

## Test plan
- IMG_W=4, IMG_H=2, memory[a]=a+0x10, `out_ready`=1, start pulse → beats 0x10..0x17 with (x,y) = (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1); `out_last` only on 0x17; `done` in cycle T0+10.
- Same setup, `pipe_pix_write`=1 during cycles T0+2..T0+4 → `pix_rd_en` low in exactly those cycles; output sequence is unchanged and `done` is delayed by 3 cycles.
- `out_ready` toggling 1,0,0,1 repeating → no dropped or duplicate beats; out_* stable while stalled; FIFO occupancy never exceeds 2.
- `start` re-pulsed mid-scan → ignored; exactly 8 beats and one `done`.
- `rst` asserted at T0+4 → all outputs at their reset values the next cycle; a new `start` produces the full sequence again from (0,0).
- IMG_W=3, IMG_H=3 (non-power-of-2) → `pix_addr` sequence 0..8 and coordinate wrap at x=2.
